pipelined_carry_increment_adder: RTL and testbench

//   Parametrised, pipelined carry-increment adder/subtractor. Next generation of the

---
 rtl/pipelined_carry_increment_adder_if.sv | 28 ++
 rtl/pipelined_carry_increment_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_carry_increment_adder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_carry_increment_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-increment adder.
interface pipelined_carry_increment_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    // Producer/consumer side: issues operations and accepts results.
    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_carry_increment_adder.sv
// Pipelined carry-increment adder/subtractor: BLOCK-bit blocks precompute sum and
// sum+1, the incoming carry selects; STAGE_BLOCKS blocks resolved per pipeline rank.
module pipelined_carry_increment_adder #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned BLOCK        = 4,
    parameter int unsigned STAGE_BLOCKS = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    pipelined_carry_increment_adder_if.slave  bus
);
    localparam int unsigned NUM_BLOCKS = WIDTH / BLOCK;
    localparam int unsigned LATENCY    = NUM_BLOCKS / STAGE_BLOCKS;
    localparam logic [BLOCK-1:0] BLK_MASK = '1;

    if ((WIDTH % BLOCK) != 0) begin : g_bad_block
        $error("WIDTH must be a multiple of BLOCK");
    end
    if ((NUM_BLOCKS % STAGE_BLOCKS) != 0) begin : g_bad_stage
        $error("STAGE_BLOCKS must divide WIDTH/BLOCK");
    end

    // Rank k holds the operands (skewed forward), the carry into the first block
    // still to be resolved, and the already finished low sum slices.
    logic             vld  [LATENCY];
    logic [WIDTH-1:0] op_a [LATENCY];
    logic [WIDTH-1:0] op_b [LATENCY];
    logic             cy   [LATENCY];
    logic [WIDTH-1:0] ps   [LATENCY];
    logic [WIDTH:0]   res  [LATENCY];

    logic             advance;
    logic [WIDTH:0]   fin;
    logic             msb_cin;

    // Resolve the STAGE_BLOCKS blocks owned by stage k; returns {carry, partial sum}.
    function automatic logic [WIDTH:0] eval_stage(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] part,
        input logic             cin,
        input int unsigned      k
    );
        logic [WIDTH-1:0] acc;
        logic             c;
        logic [BLOCK-1:0] xa;
        logic [BLOCK-1:0] yb;
        logic [BLOCK-1:0] s0;
        logic [BLOCK-1:0] s1;
        logic             c0;
        logic             c1;
        int unsigned      sh;
        acc = part;
        c   = cin;
        for (int unsigned i = 0; i < STAGE_BLOCKS; i++) begin
            sh        = (k * STAGE_BLOCKS + i) * BLOCK;
            xa        = BLOCK'(x >> sh);
            yb        = BLOCK'(y >> sh);
            {c0, s0}  = {1'b0, xa} + {1'b0, yb};
            s1        = s0 + BLOCK'(1);
            c1        = c0 | (&s0);
            acc       = (acc & ~(WIDTH'(BLK_MASK) << sh)) | (WIDTH'(c ? s1 : s0) << sh);
            c         = c ? c1 : c0;
        end
        return {c, acc};
    endfunction

    // Whole pipe moves whenever the output slot is free or being drained.
    assign advance      = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < LATENCY; k++) begin : g_eval
        assign res[k] = eval_stage(op_a[k], op_b[k], ps[k], cy[k], k);
    end

    // Carry into the MSB recovered from the final sum bit and its operand bits.
    assign fin     = res[LATENCY-1];
    assign msb_cin = op_a[LATENCY-1][WIDTH-1] ^ op_b[LATENCY-1][WIDTH-1] ^ fin[WIDTH-1];

    // Rank 0: capture operands, folding subtract into inverted B with carry-in 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld[0]  <= 1'b0;
            op_a[0] <= '0;
            op_b[0] <= '0;
            cy[0]   <= 1'b0;
            ps[0]   <= '0;
        end else if (advance) begin
            vld[0]  <= bus.in_valid;
            op_a[0] <= bus.a;
            op_b[0] <= bus.sub ? ~bus.b : bus.b;
            cy[0]   <= bus.sub | bus.carry_in;
            ps[0]   <= '0;
        end
    end

    for (genvar r = 1; r < LATENCY; r++) begin : g_rank
        // Rank r: take the previous stage's carry and sum slices, skew operands on.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[r]  <= 1'b0;
                op_a[r] <= '0;
                op_b[r] <= '0;
                cy[r]   <= 1'b0;
                ps[r]   <= '0;
            end else if (advance) begin
                vld[r]  <= vld[r-1];
                op_a[r] <= op_a[r-1];
                op_b[r] <= op_b[r-1];
                cy[r]   <= res[r-1][WIDTH];
                ps[r]   <= res[r-1][WIDTH-1:0];
            end
        end
    end

    // Output rank: result registers, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= vld[LATENCY-1];
            bus.sum       <= fin[WIDTH-1:0];
            bus.carry_out <= fin[WIDTH];
            bus.overflow  <= msb_cin ^ fin[WIDTH];
        end
    end
endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Scoreboard bench: directed checks on an 8/4/1 instance, random traffic on both.
module tb_pipelined_carry_increment_adder;
    localparam int unsigned L8 = 2;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [33:0] q8[$];
    logic [33:0] q32[$];

    pipelined_carry_increment_adder_if #(.WIDTH(8))  if8 ();
    pipelined_carry_increment_adder_if #(.WIDTH(32)) if32 ();

    pipelined_carry_increment_adder #(.WIDTH(8), .BLOCK(4), .STAGE_BLOCKS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8)
    );
    pipelined_carry_increment_adder dut32 (
        .clk(clk), .rst_n(rst_n), .bus(if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic ov, input logic co, input logic [31:0] s);
        return {ov, co, s};
    endfunction

    // Reference: plain integer arithmetic on w-bit operands, signed overflow by sign rule.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint unsigned m, ua, ub, t;
        logic co, ov, sa, sb, ss;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, (sub ? ~b : b)} & m;
        t  = ua + ub + (sub ? 64'd1 : {63'd0, cin});
        co = 1'((t >> w) & 64'd1);
        sa = 1'(ua >> (w - 1));
        sb = 1'(ub >> (w - 1));
        ss = 1'(t >> (w - 1));
        ov = (sa == sb) && (ss != sa);
        return {ov, co, 32'(t & m)};
    endfunction

    // Result monitors: pop expected value on every completed output transfer.
    always @(negedge clk) begin
        if (rst_n && if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) chk("unexpected8", 64'(if8.sum), 64'hDEAD);
            else chk("result8", 64'(mk(if8.overflow, if8.carry_out, 32'(if8.sum))), 64'(q8.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && if32.out_valid && if32.out_ready) begin
            if (q32.size() == 0) chk("unexpected32", 64'(if32.sum), 64'hDEAD);
            else chk("result32", 64'(mk(if32.overflow, if32.carry_out, if32.sum)), 64'(q32.pop_front()));
        end
    end

    // Present one op to the 8-bit DUT and hold it until accepted.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [33:0] exp);
        bit done = 1'b0;
        if8.in_valid = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.carry_in = cin;
        if8.sub = sub;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (if8.in_ready) begin
                q8.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if8.in_valid = 1'b0;
        if (!done) chk("send8_timeout", 64'(done), 64'd1);
    endtask

    task automatic send8_rand();
        logic [7:0] a, b;
        logic cin, sub;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        send8(a, b, cin, sub, model(8, 32'(a), 32'(b), cin, sub));
    endtask

    // Op accepted at edge N must show out_valid only after edge N+L8.
    task automatic latency8(input string name);
        for (int j = 0; j <= int'(L8); j++) begin
            @(negedge clk);
            chk(name, 64'(if8.out_valid), 64'(j == int'(L8)));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain8();
        for (int i = 0; i < 50 && q8.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain8", 64'(q8.size()), 64'd0);
    endtask

    task automatic rand8(input int n);
        int sent = 0;
        for (int cyc = 0; cyc < 40 * n + 100 && (sent < n || q8.size() != 0); cyc++) begin
            if8.out_ready = (sent >= n) || ($urandom_range(3) != 0);
            if8.in_valid  = (sent < n) && ($urandom_range(3) != 0);
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.carry_in = 1'($urandom);
            if8.sub = 1'($urandom);
            @(negedge clk);
            if (if8.in_valid && if8.in_ready) begin
                q8.push_back(model(8, 32'(if8.a), 32'(if8.b), if8.carry_in, if8.sub));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        chk("rand8_done", 64'(sent == n && q8.size() == 0), 64'd1);
    endtask

    task automatic rand32(input int n);
        int sent = 0;
        for (int cyc = 0; cyc < 40 * n + 100 && (sent < n || q32.size() != 0); cyc++) begin
            if32.out_ready = (sent >= n) || ($urandom_range(3) != 0);
            if32.in_valid  = (sent < n) && ($urandom_range(3) != 0);
            if32.a = $urandom;
            if32.b = $urandom;
            if32.carry_in = 1'($urandom);
            if32.sub = 1'($urandom);
            @(negedge clk);
            if (if32.in_valid && if32.in_ready) begin
                q32.push_back(model(32, if32.a, if32.b, if32.carry_in, if32.sub));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        if32.in_valid = 1'b0;
        if32.out_ready = 1'b1;
        chk("rand32_done", 64'(sent == n && q32.size() == 0), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        if8.in_valid = 1'b0;  if8.out_ready = 1'b1;
        if8.a = '0; if8.b = '0; if8.carry_in = 1'b0; if8.sub = 1'b0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        if32.a = '0; if32.b = '0; if32.carry_in = 1'b0; if32.sub = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset8_outs", 64'({if8.out_valid, if8.sum, if8.carry_out, if8.overflow}), 64'd0);
        chk("reset8_in_ready", 64'(if8.in_ready), 64'd1);
        chk("reset32_outs", 64'({if32.out_valid, if32.carry_out, if32.overflow}), 64'd0);
        chk("reset32_sum", 64'(if32.sum), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add, latency, full ripple+increment, signed overflow, subtract.
        send8(8'h1B, 8'h35, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h50));
        latency8("t1_latency");
        send8(8'hFF, 8'h01, 1'b1, 1'b0, mk(1'b0, 1'b1, 32'h01));
        send8(8'h7F, 8'h01, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h80));
        send8(8'h05, 8'h07, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'hFE));
        drain8();

        // Back-to-back ops with the consumer stalling for 3 cycles.
        send8(8'h1B, 8'h35, 1'b0, 1'b0, mk(1'b0, 1'b0, 32'h50));
        send8(8'hFF, 8'h01, 1'b1, 1'b0, mk(1'b0, 1'b1, 32'h01));
        send8(8'h7F, 8'h01, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h80));
        for (int i = 0; i < 20 && !if8.out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_in_ready", 64'(if8.in_ready), 64'd0);
            chk("t4_frozen", 64'({if8.out_valid, if8.carry_out, if8.overflow, if8.sum}), 64'h450);
        end
        @(posedge clk);
        #1;
        if8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stream", 64'(if8.out_valid), 64'(i < 3));
        end
        drain8();

        // Reset while ops are in flight.
        send8_rand();
        send8_rand();
        send8_rand();
        chk("t5_pre_valid", 64'(if8.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outs", 64'({if8.out_valid, if8.sum, if8.carry_out, if8.overflow}), 64'd0);
        chk("t5_reset_in_ready", 64'(if8.in_ready), 64'd1);
        q8.delete();
        q32.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send8(8'h80, 8'h80, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h00));
        latency8("t5_latency");
        drain8();

        rand8(300);
        rand32(10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
